// File: rtl/matrix_bram_arbiter.sv
// -----------------------------------------------------------------------------
// matrix_bram_arbiter
//
// Shares the single read port of the matrix storage BRAM between NUM_REQ
// requesters (matrix reader/printer, compute operand fetch, matrix selector).
// A requester that wins arbitration holds a locked session until it drops req.
// Sessions are handed out round-robin. The owner's address and read strobe are
// muxed onto the BRAM. Read data is broadcast, and a per-requester valid strobe
// is aligned to the BRAM's one-cycle read latency.
//
// Handshake: req is a level held for the whole session. gnt (registered,
// one-hot) marks the owner. While gnt[i] is high, every cycle with rd_en[i]=1
// is one BRAM read at rd_addr slice i. rd_valid[i] follows one cycle later,
// together with rd_data. Requesters without a grant are ignored. Dropping req
// ends the session. A read issued in that same last cycle still completes, in
// the one-cycle DRAIN state that follows.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   req[NUM_REQ]        per-requester session request (level)
//   rd_en[NUM_REQ]      per-requester read strobe (owner only)
//   rd_addr             packed addresses, slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
//   gnt[NUM_REQ]        one-hot grant (registered)
//   rd_valid[NUM_REQ]   read data valid per requester (registered)
//   rd_data             broadcast read data (= bram_data)
//   bram_addr/bram_en   BRAM read port, driven by the owner only
//   bram_data           BRAM output, valid one cycle after bram_en
//   busy                high outside IDLE
//   owner               index of the grant holder, 0 when none
//   wdog_err            sticky watchdog error
//
// Optional feature: define MATRIX_ARB_WATCHDOG_EN to revoke a grant after
// IDLE_LIMIT consecutive owner cycles without rd_en. Without the macro,
// wdog_err is tied low.
// The FSM state is visible as the signal 'state' for debug probing.
// -----------------------------------------------------------------------------
module matrix_bram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int IDLE_LIMIT = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            rd_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic                          bram_en,
  input  logic [DATA_WIDTH-1:0]         bram_data,
  output logic                          busy,
  output logic [2:0]                    owner,
  output logic                          wdog_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]           state;
  logic [2:0]           rr_ptr;
  logic [NUM_REQ-1:0]   eligible;
  logic [2*NUM_REQ-1:0] eligible_dbl;
  logic [2*NUM_REQ-1:0] eligible_rot;
  logic                 pick_found;
  logic [2:0]           pick_idx;
  int                   scan_k;
  logic                 release_req;
  logic                 wd_fire;
  logic [2:0]           next_ptr;

  // Rotating the doubled request vector right by rr_ptr puts the round-robin
  // start position at bit 0, so the scan below works on constant bit indices.
  assign eligible_dbl = {eligible, eligible};
  assign eligible_rot = eligible_dbl >> rr_ptr;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    scan_k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && eligible_rot[i]) begin
        pick_found = 1'b1;
        scan_k     = int'(rr_ptr) + i;
        if (scan_k >= NUM_REQ) scan_k = scan_k - NUM_REQ;
        pick_idx   = 3'(scan_k);
      end
    end
  end

  // BRAM port mux. gnt is one-hot and all-zero outside GRANT, so when no grant
  // is held the port reads as address 0 with the enable low.
  always_comb begin
    bram_en   = 1'b0;
    bram_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        bram_en   = rd_en[i];
        bram_addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // The owner releases the session by dropping its own req bit.
  assign release_req = (state == ST_GRANT) && ((req & gnt) == '0);
  assign next_ptr    = (owner == 3'(NUM_REQ - 1)) ? 3'd0 : owner + 3'd1;

  assign rd_data = bram_data;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= 3'd0;
      gnt      <= '0;
      owner    <= 3'd0;
      rd_valid <= '0;
    end else begin
      // The valid strobe is registered on the same edge as the BRAM output.
      rd_valid <= bram_en ? gnt : '0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            owner <= pick_idx;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (release_req || wd_fire) begin
            gnt    <= '0;
            owner  <= 3'd0;
            rr_ptr <= next_ptr;
            state  <= ST_DRAIN;
          end
        end
        ST_DRAIN: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef MATRIX_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(IDLE_LIMIT + 1);

  logic [CNT_W-1:0]   idle_cnt;
  logic [NUM_REQ-1:0] blocked;
  logic               owner_rd;

  assign owner_rd = |(rd_en & gnt);
  // Fires on the IDLE_LIMIT-th consecutive idle owner cycle. A voluntary
  // release in the same cycle takes priority and is not flagged as an error.
  assign wd_fire  = (state == ST_GRANT) && !release_req && !owner_rd &&
                    (idle_cnt == CNT_W'(IDLE_LIMIT - 1));
  // A revoked requester stays blocked until it has dropped req for a cycle.
  assign eligible = req & ~blocked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      blocked  <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state == ST_GRANT && !owner_rd) idle_cnt <= idle_cnt + 1'b1;
      else                                idle_cnt <= '0;
      if (wd_fire) begin
        blocked  <= (blocked & req) | gnt;
        wdog_err <= 1'b1;
      end else begin
        blocked  <= blocked & req;
      end
    end
  end
`else
  assign wd_fire  = 1'b0;
  assign eligible = req;
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_bram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_matrix_bram_arbiter
//
// Self-checking bench for matrix_bram_arbiter (NUM_REQ=4). A behavioural model
// tracks the session holder, the drain gap and the round-robin pointer. The
// model predicts the BRAM port, grant, owner, busy and read-valid/data outputs
// every cycle. Directed sequences are followed by randomized sessions.
// -----------------------------------------------------------------------------
module tb_matrix_bram_arbiter;
  localparam int N  = 4;
  localparam int AW = 14;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req     = '0;
  logic [N-1:0]    rd_en   = '0;
  logic [N*AW-1:0] rd_addr = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rd_valid;
  logic [DW-1:0]   rd_data;
  logic [AW-1:0]   bram_addr;
  logic            bram_en;
  logic [DW-1:0]   bram_data = '0;
  logic            busy;
  logic [2:0]      owner;
  logic            wdog_err;

  matrix_bram_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDLE_LIMIT(1024)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .rd_en(rd_en), .rd_addr(rd_addr),
    .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_data(bram_data),
    .busy(busy), .owner(owner), .wdog_err(wdog_err)
  );

  // BRAM contents are a fixed function of the address.
  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return 32'h5A00_0000 ^ ({18'd0, a} * 32'd40503);
  endfunction

  always @(posedge clk) if (bram_en) bram_data <= word_at(bram_addr);

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            m_holder = -1;  // requester holding the session, -1 for none
  bit            m_drain  = 0;   // the one gap cycle after a release
  int            m_ptr    = 0;   // where the next arbitration scan starts
  logic [N-1:0]  m_valid  = '0;
  logic [DW-1:0] m_data   = '0;
  logic [DW-1:0] exp_q[$];       // read data expected for the current valid

  function automatic logic [AW-1:0] addr_of(input int i);
    return rd_addr[i*AW +: AW];
  endfunction

  task automatic model_reset();
    m_holder = -1; m_drain = 0; m_ptr = 0; m_valid = '0;
    exp_q.delete();
  endtask

  // Advance the model across one rising edge, using the inputs just sampled.
  task automatic model_edge();
    bit read_now;
    read_now = (m_holder >= 0) && rd_en[m_holder];
    exp_q.delete();
    if (read_now) begin
      m_valid = N'(1) << m_holder;
      m_data  = word_at(addr_of(m_holder));
      exp_q.push_back(m_data);
    end else begin
      m_valid = '0;
    end
    if (m_holder >= 0) begin
      if (!req[m_holder]) begin
        m_ptr    = (m_holder + 1) % N;
        m_holder = -1;
        m_drain  = 1;
      end
    end else if (m_drain) begin
      m_drain = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_holder < 0 && req[(m_ptr + k) % N]) m_holder = (m_ptr + k) % N;
      end
    end
  endtask

  task automatic check_comb();
    check("bram_en", bram_en, (m_holder >= 0) ? rd_en[m_holder] : 1'b0);
    check("bram_addr", bram_addr, (m_holder >= 0) ? addr_of(m_holder) : '0);
  endtask

  task automatic check_regs();
    check("gnt", gnt, (m_holder >= 0) ? (N'(1) << m_holder) : N'(0));
    check("owner", owner, (m_holder >= 0) ? m_holder : 0);
    check("busy", busy, (m_holder >= 0) || m_drain);
    check("rd_valid", rd_valid, m_valid);
    check("wdog_err", wdog_err, 1'b0);
    if (exp_q.size() > 0) check("rd_data", rd_data, exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge: apply inputs, check the combinational
  // port, cross the next edge, then check the registered outputs.
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] e,
                       input logic [N*AW-1:0] a);
    req = r; rd_en = e; rd_addr = a;
    #1;
    check_comb();
    @(posedge clk);
    #1;
    model_edge();
    check_regs();
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_regs();
    check_comb();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_regs();
  endtask

  function automatic logic [N*AW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  // ---------------- stimulus ----------------
  logic [N-1:0]    rq;
  logic [N-1:0]    re;
  logic [N*AW-1:0] ra;
  int              sess[N];
  int              phase;
  int              n_grants;
  int              prev_holder;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_regs();
    check_comb();
    rst = 1'b0;

    // Single requester: grant one cycle later, three reads, release
    cycle(4'b0010, 4'b0000, pk(0, 0, 0, 0));
    check("single_gnt", gnt, 4'b0010);
    for (int i = 0; i < 3; i++) cycle(4'b0010, 4'b0010, pk(0, i, 0, 0));
    cycle(4'b0000, 4'b0000, pk(0, 0, 0, 0));
    repeat (3) cycle(4'b0000, 4'b0000, pk(0, 0, 0, 0));

    // Contention/fairness from a fresh pointer: all request, 2 reads each
    mid_reset();
    phase = 0; n_grants = 0;
    for (int c = 0; c < 40; c++) begin
      rq = 4'b1111; re = '0;
      prev_holder = m_holder;
      if (m_holder >= 0) begin
        if (phase < 2) begin re[m_holder] = 1'b1; phase++; end
        else begin rq[m_holder] = 1'b0; phase = 0; end
      end
      cycle(rq, re, pk(c, c + 100, c + 200, c + 300));
      if (prev_holder < 0 && m_holder >= 0) begin
        check("grant_order", owner, n_grants % N);
        n_grants++;
      end
    end
    repeat (4) cycle(4'b0000, 4'b0000, pk(0, 0, 0, 0));

    // Release with a pending read: data returns in DRAIN with gnt low
    cycle(4'b0001, 4'b0000, pk(0, 0, 0, 0));
    cycle(4'b0000, 4'b0001, pk(5, 0, 0, 0));
    check("drain_valid", rd_valid, 4'b0001);
    check("drain_gnt", gnt, 4'b0000);
    repeat (2) cycle(4'b0000, 4'b0000, pk(0, 0, 0, 0));

    // Non-owner isolation: requester 2 strobes while 0 owns
    cycle(4'b0001, 4'b0000, pk(0, 0, 0, 0));
    repeat (3) cycle(4'b0101, 4'b0101, pk(10, 0, 99, 0));
    cycle(4'b0100, 4'b0100, pk(10, 0, 99, 0));
    repeat (3) cycle(4'b0100, 4'b0100, pk(0, 0, 99, 0));
    repeat (3) cycle(4'b0000, 4'b0000, pk(0, 0, 0, 0));

    // Reset during a burst by owner 3, then 1001 must pick 0 first
    cycle(4'b1000, 4'b0000, pk(0, 0, 0, 0));
    for (int i = 0; i < 3; i++) cycle(4'b1000, 4'b1000, pk(0, 0, 0, 40 + i));
    mid_reset();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_busy", busy, 1'b0);
    cycle(4'b1001, 4'b0000, pk(0, 0, 0, 0));
    check("post_rst_gnt", gnt, 4'b0001);
    repeat (6) cycle(4'b0000, 4'b0000, pk(0, 0, 0, 0));

    // Randomized sessions
    rq = '0;
    for (int i = 0; i < N; i++) sess[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      re = '0;
      for (int i = 0; i < N; i++) begin
        ra[i*AW +: AW] = AW'($urandom_range(0, (1 << AW) - 1));
        if (m_holder == i) begin
          if (sess[i] == 0) sess[i] = $urandom_range(1, 6);
          sess[i]--;
          re[i] = ($urandom_range(0, 3) != 0);
          if (sess[i] == 0) rq[i] = 1'b0;
        end else begin
          if (!rq[i]) rq[i] = ($urandom_range(0, 3) == 0);
          re[i] = $urandom_range(0, 1);
        end
      end
      cycle(rq, re, ra);
      if ($urandom_range(0, 499) == 0) begin
        mid_reset();
        for (int i = 0; i < N; i++) sess[i] = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
